// File: rtl/lifo_arb_pkg.sv
// Shared types and constants for the two-requester LIFO arbiter.
package lifo_arb_pkg;

    localparam int REQ_N = 2;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Which requesters may be granted in a given arbitration state.
    function automatic logic [REQ_N-1:0] owner_mask(input arb_state_e s);
        case (s)
            OWN0:    owner_mask = 2'b01;
            OWN1:    owner_mask = 2'b10;
            default: owner_mask = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/lifo_arb_rr.sv
// Two-way round-robin grant with an owner mask and rr pointer register.
// The grant is combinational; it is only ever set for a valid requester.
module lifo_arb_rr
    import lifo_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REQ_N-1:0] valid_i,
    input  logic [REQ_N-1:0] mask_i,
    output logic [REQ_N-1:0] grant_o
);

    // rr_q = 0 favours requester 0 when both compete.
    logic rr_q;
    logic rr_d;
    logic [REQ_N-1:0] cand;

    assign cand = valid_i & mask_i;

    // Pick a single winner among masked valid requesters.
    always_comb begin
        grant_o = cand;
        if (cand == 2'b11) begin
            grant_o = rr_q ? 2'b10 : 2'b01;
        end
    end

    // After a transfer, favour the requester that did not just win.
    always_comb begin
        rr_d = rr_q;
        if (grant_o != 2'b00) begin
            rr_d = grant_o[0];
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Shared LIFO stack arbitrated between two requesters, with per-requester
// locking for atomic op sequences. Optional sticky error flags are built
// when STACK_ERR_STICKY_EN is defined.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [REQ_N-1:0]              req_valid,
    output logic [REQ_N-1:0]              req_ready,
    input  logic [REQ_N-1:0]              req_op,
    input  logic [REQ_N-1:0]              req_lock,
    input  logic [REQ_N*DATA_WIDTH-1:0]   req_wdata,
    output logic [REQ_N-1:0]              rsp_valid,
    output logic [REQ_N-1:0]              rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          empty,
    output logic                          full
`ifdef STACK_ERR_STICKY_EN
    ,
    output logic [REQ_N-1:0]              err_sticky,
    input  logic                          err_clr
`endif
);

    localparam int                  DEPTH_N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    arb_state_e state_q;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    empty_q, full_q;
    logic [REQ_N-1:0]        rsp_valid_q, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH_N];

    logic [REQ_N-1:0]        grant;
    logic                    sel;
    logic                    is_push;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    do_write, do_read, op_err;
    logic [ADDR_WIDTH-1:0]   wr_idx, rd_idx;

    lifo_arb_rr u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (req_valid),
        .mask_i  (owner_mask(state_q)),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign sel       = grant[1];
    assign is_push   = (op_e'(sel ? req_op[1] : req_op[0]) == OP_PUSH);
    assign wdata     = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
    assign wr_idx    = count_q[ADDR_WIDTH-1:0];
    assign rd_idx    = count_q[ADDR_WIDTH-1:0] - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Decide the effect of the granted op: grow, shrink, or flag an error.
    always_comb begin
        count_d  = count_q;
        do_write = 1'b0;
        do_read  = 1'b0;
        op_err   = 1'b0;
        if (grant != 2'b00) begin
            if (is_push) begin
                if (count_q != DEPTH) begin
                    count_d  = count_q + ONE;
                    do_write = 1'b1;
                end else begin
                    op_err = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - ONE;
                    do_read = 1'b1;
                end else begin
                    op_err = 1'b1;
                end
            end
        end
        rsp_err_d = grant & {REQ_N{op_err}};
    end

    // Stack storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_idx] <= wdata;
        end
    end

    // Occupancy, flags and one-cycle response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            full_q      <= (count_d == DEPTH);
            rsp_valid_q <= grant;
            rsp_err_q   <= rsp_err_d;
            if (do_read) begin
                rsp_rdata_q <= mem[rd_idx];
            end
        end
    end

    // Lock FSM: a locked transfer claims the stack, dropping lock releases it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant[0] && req_lock[0]) begin
                        state_q <= OWN0;
                    end else if (grant[1] && req_lock[1]) begin
                        state_q <= OWN1;
                    end
                end
                OWN0:    if (!req_lock[0]) state_q <= IDLE;
                OWN1:    if (!req_lock[1]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;

`ifdef STACK_ERR_STICKY_EN
    logic [REQ_N-1:0] err_sticky_q;

    // Sticky error flags rise with rsp_err; a new error beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky_q <= '0;
        end else begin
            err_sticky_q <= (err_sticky_q & ~{REQ_N{err_clr}}) | rsp_err_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// Randomized self-checking bench for lifo_arbiter against a queue-based
// reference model of the shared stack, round-robin and lock ownership.
module tb_lifo_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_op = '0;
    logic [1:0]        req_lock = '0;
    logic [2*DW-1:0]   req_wdata = '0;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
`ifdef STACK_ERR_STICKY_EN
    logic [1:0]        err_sticky;
    logic              err_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    lifo_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_lock   (req_lock),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .count      (count),
        .empty      (empty),
        .full       (full)
`ifdef STACK_ERR_STICKY_EN
        ,
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] stk[$];
    int            owner;     // -1 = unlocked
    int            fav;       // requester preferred when both are valid
    logic [1:0]    e_rv;
    logic [1:0]    e_re;
    logic [DW-1:0] e_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        owner = -1;
        fav   = 0;
        e_rv  = '0;
        e_re  = '0;
        e_rd  = '0;
    endtask

    task automatic check_outputs();
        check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check_eq("rsp_err",   32'(rsp_err),   32'(e_re));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
        check_eq("count",     32'(count),     32'(stk.size()));
        check_eq("empty",     32'(empty),     32'(stk.size() == 0));
        check_eq("full",      32'(full),      32'(stk.size() == DEPTH));
    endtask

    // One cycle: check last edge's results, apply new random inputs,
    // check the grant, then advance the model to the next edge.
    task automatic step(input int push_pct, input int lock_pct);
        logic [1:0]    g;
        int            w;
        logic [DW-1:0] wd;
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = ($urandom_range(0, 99) < 70);
            req_op[i]    = ($urandom_range(0, 99) < push_pct);
            req_lock[i]  = ($urandom_range(0, 99) < lock_pct);
        end
        req_wdata = 16'($urandom);
        #1;
        if (owner >= 0)           g = req_valid[owner] ? 2'(1 << owner) : 2'b00;
        else if (req_valid == 3)  g = (fav == 0) ? 2'b01 : 2'b10;
        else                      g = req_valid;
        check_eq("req_ready", 32'(req_ready), 32'(g));
        e_rv = g;
        e_re = '0;
        w    = g[1] ? 1 : 0;
        if (g != 0) begin
            wd = (w == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            if (req_op[w]) begin
                if (stk.size() < DEPTH) stk.push_back(wd);
                else                    e_re = g;
            end else begin
                if (stk.size() > 0) e_rd = stk.pop_back();
                else                e_re = g;
            end
            fav = (w == 0) ? 1 : 0;
            $display("xfer req%0d %s wdata=%02h err=%0d depth_after=%0d lock=%0d",
                     w, req_op[w] ? "push" : "pop ", wd, e_re != 0, stk.size(), req_lock[w]);
        end
        if (owner < 0) begin
            if (g != 0 && req_lock[w]) owner = w;
        end else if (!req_lock[owner]) begin
            owner = -1;
        end
    endtask

    initial begin
        int tries;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        repeat (150) step(90, 0);
        repeat (150) step(90, 30);
        repeat (150) step(50, 50);
        repeat (150) step(10, 20);
        repeat (150) step(10, 0);
        repeat (150) step(60, 80);

        // Reset in the middle of a burst while a response is pending.
        tries = 0;
        do begin
            step(80, 20);
            tries++;
        end while (e_rv == 0 && tries < 50);
        @(negedge clk);
        check_eq("pending_rsp", 32'(rsp_valid != 0), 32'(e_rv != 0));
        reset_n   = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        repeat (200) step(70, 30);
        repeat (100) step(20, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
